// File: rtl/progmem_loader.sv
// Boot-time program-memory loader: packs a byte stream into LE 32-bit words and writes them over Avalon-MM.
// Optional read-back verify when PROGMEM_LOADER_VERIFY_EN is defined.
module progmem_loader #(
  parameter int                ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-3:0] word_count,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  output logic              m_read,
  input  logic [31:0]       m_readdata,
  input  logic [1:0]        m_response,
  input  logic              m_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_rst_n
);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_READ, S_ADVANCE, S_DONE} state_t;

  state_t            r_state, w_nstate;
  logic [ADDR_W-3:0] r_rem;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_byte_idx;
  logic              r_error, r_cpu_rst_n;
  logic              r_s_ready, r_m_write, r_m_read, r_busy, r_done;
  logic              w_set_err, w_err_d;
  logic              w_s_ready_d, w_m_write_d, w_m_read_d, w_busy_d, w_done_d, w_cpu_rst_n_d;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nstate;

  always_comb begin
    w_nstate  = r_state;
    w_set_err = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_nstate = (word_count == '0) ? S_DONE : S_COLLECT;
      S_COLLECT: if (s_valid && r_byte_idx == 2'd3) w_nstate = S_WRITE;
      S_WRITE:
        if (!m_waitrequest) begin
          if (m_response != 2'b00) begin
            w_set_err = 1'b1;
            w_nstate  = S_DONE;
          end else begin
`ifdef PROGMEM_LOADER_VERIFY_EN
            w_nstate = S_READ;
`else
            w_nstate = S_ADVANCE;
`endif
          end
        end
`ifdef PROGMEM_LOADER_VERIFY_EN
      S_READ:
        if (!m_waitrequest) begin
          if (m_response != 2'b00 || m_readdata != r_wdata) begin
            w_set_err = 1'b1;
            w_nstate  = S_DONE;
          end else begin
            w_nstate = S_ADVANCE;
          end
        end
`endif
      S_ADVANCE: w_nstate = (r_rem == (ADDR_W-2)'(1)) ? S_DONE : S_COLLECT;
      S_DONE:    w_nstate = S_IDLE;
      default:   w_nstate = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    w_err_d        = (r_state == S_IDLE && start) ? 1'b0 : (r_error | w_set_err);
    w_s_ready_d    = (w_nstate == S_COLLECT);
    w_m_write_d    = (w_nstate == S_WRITE);
    w_m_read_d     = (w_nstate == S_READ);
    w_busy_d       = (w_nstate != S_IDLE);
    w_done_d       = (w_nstate == S_DONE);
    w_cpu_rst_n_d  = r_cpu_rst_n | (w_done_d & ~w_err_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem       <= '0;
      r_addr      <= BASE_ADDR;
      r_wdata     <= '0;
      r_byte_idx  <= '0;
      r_error     <= 1'b0;
      r_cpu_rst_n <= 1'b0;
      r_s_ready   <= 1'b0;
      r_m_write   <= 1'b0;
      r_m_read    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_error     <= w_err_d;
      r_cpu_rst_n <= w_cpu_rst_n_d;
      r_s_ready   <= w_s_ready_d;
      r_m_write   <= w_m_write_d;
      r_m_read    <= w_m_read_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      if (r_state == S_IDLE && start) begin
        r_rem      <= word_count;
        r_addr     <= BASE_ADDR;
        r_byte_idx <= '0;
      end
      if (r_state == S_COLLECT && s_valid) begin
        r_wdata[{r_byte_idx, 3'b000} +: 8] <= s_data;
        r_byte_idx                         <= r_byte_idx + 2'd1;
      end
      // Address wraps modulo 2^ADDR_W by width.
      if (r_state == S_ADVANCE) begin
        r_addr <= r_addr + ADDR_W'(4);
        r_rem  <= r_rem - (ADDR_W-2)'(1);
      end
    end
  end

  assign s_ready      = r_s_ready;
  assign m_address    = r_addr;
  assign m_write      = r_m_write;
  assign m_writedata  = r_wdata;
  assign m_byteenable = r_m_write ? 4'hF : 4'h0;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign cpu_rst_n    = r_cpu_rst_n;

`ifdef PROGMEM_LOADER_VERIFY_EN
  assign m_read = r_m_read;
`else
  logic w_unused;
  assign w_unused = ^{m_readdata, r_m_read};
  assign m_read   = 1'b0;
`endif

endmodule

// File: tb/tb_progmem_loader.sv
// Directed bench for progmem_loader: two instances (BASE 0 and BASE 0x3FFC) run in lockstep off one slave model.
module tb_progmem_loader;
  localparam int AW = 14;

  logic          clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [AW-3:0] word_count = '0;
  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0;
  logic [31:0]   m_readdata;
  logic [1:0]    m_response;
  logic          m_waitrequest;

  logic          a_ready, a_write, a_read, a_busy, a_done, a_error, a_cpu;
  logic [AW-1:0] a_address;
  logic [31:0]   a_wdata;
  logic [3:0]    a_be;
  logic          w_ready, w_write, w_read, w_busy, w_done, w_error, w_cpu;
  logic [AW-1:0] w_address;
  logic [31:0]   w_wdata;
  logic [3:0]    w_be;

  progmem_loader #(.ADDR_W(AW), .BASE_ADDR(14'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .s_data(s_data), .s_valid(s_valid), .s_ready(a_ready),
    .m_address(a_address), .m_write(a_write), .m_writedata(a_wdata), .m_byteenable(a_be),
    .m_read(a_read), .m_readdata(m_readdata), .m_response(m_response), .m_waitrequest(m_waitrequest),
    .busy(a_busy), .done(a_done), .error(a_error), .cpu_rst_n(a_cpu));

  progmem_loader #(.ADDR_W(AW), .BASE_ADDR(14'h3FFC)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .s_data(s_data), .s_valid(s_valid), .s_ready(w_ready),
    .m_address(w_address), .m_write(w_write), .m_writedata(w_wdata), .m_byteenable(w_be),
    .m_read(w_read), .m_readdata(m_readdata), .m_response(m_response), .m_waitrequest(m_waitrequest),
    .busy(w_busy), .done(w_done), .error(w_error), .cpu_rst_n(w_cpu));

  // Slave: stall each request for wait_cycles cycles, then accept.
  int  wait_cycles = 0;
  int  wcnt = 0;
  bit  resp_err = 1'b0, corrupt = 1'b0;
  logic req;
  assign req           = a_write | a_read;
  assign m_waitrequest = req && (wcnt < wait_cycles);
  assign m_response    = resp_err ? 2'b10 : 2'b00;
  assign m_readdata    = corrupt ? 32'hDEADBEEF : a_wdata;
  always @(posedge clk)
    if (!req || !m_waitrequest) wcnt <= 0;
    else                        wcnt <= wcnt + 1;

  // Monitor of accepted writes and done pulses.
  logic [AW-1:0] addr_q[$];
  logic [AW-1:0] waddr_q[$];
  logic [31:0]   data_q[$];
  logic [3:0]    be_q[$];
  int            hold_q[$];
  int            hold = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (a_write && !m_waitrequest) begin
      addr_q.push_back(a_address);
      waddr_q.push_back(w_address);
      data_q.push_back(a_wdata);
      be_q.push_back(a_be);
      hold_q.push_back(hold + 1);
    end
    if (a_write && m_waitrequest) hold <= hold + 1;
    else                          hold <= 0;
    if (a_done) done_cnt <= done_cnt + 1;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int wc);
    @(negedge clk);
    word_count = wc[AW-3:0];
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    s_data  = b;
    s_valid = 1'b1;
    while (!a_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("s_ready_tmo", 32'd0, 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("done_tmo", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] img_a[8];
  logic [7:0] img_b[8];
  int n0, d0, t;

  initial begin
    img_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    img_b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
    repeat (3) @(negedge clk);

    chk("rst_cpu_rst_n", a_cpu,     0);
    chk("rst_s_ready",   a_ready,   0);
    chk("rst_m_write",   a_write,   0);
    chk("rst_m_read",    a_read,    0);
    chk("rst_busy",      a_busy,    0);
    chk("rst_done",      a_done,    0);
    chk("rst_error",     a_error,   0);
    chk("rst_addr",      a_address, 14'h0000);
    chk("rst_addr_w",    w_address, 14'h3FFC);
    chk("rst_wdata",     a_wdata,   0);
    chk("rst_be",        a_be,      0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted in the middle of a stalled write.
    wait_cycles = 7;
    pulse_start(1);
    for (int i = 0; i < 4; i++) send(img_a[i], 0);
    t = 0;
    while (!a_write && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("midrst_wr_seen", a_write, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_write", a_write, 0);
    chk("midrst_busy",    a_busy,  0);
    chk("midrst_cpu",     a_cpu,   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reload from BASE after reset; slave error response on the first write.
    n0 = addr_q.size(); d0 = done_cnt;
    resp_err = 1'b1; wait_cycles = 2;
    pulse_start(2);
    for (int i = 0; i < 4; i++) send(img_b[i], 0);
    wait_done(d0);
    chk("serr_nwr",   addr_q.size() - n0, 1);
    if (addr_q.size() > n0) chk("reload_addr", addr_q[n0], 14'h0000);
    chk("serr_error", a_error, 1);
    chk("serr_cpu",   a_cpu,   0);
    chk("serr_done",  done_cnt - d0, 1);
    resp_err = 1'b0;

`ifdef PROGMEM_LOADER_VERIFY_EN
    // Read-back returns the wrong word.
    n0 = addr_q.size(); d0 = done_cnt;
    corrupt = 1'b1;
    pulse_start(2);
    for (int i = 0; i < 4; i++) send(img_a[i], 0);
    wait_done(d0);
    repeat (10) @(negedge clk);
    chk("vfy_nwr",   addr_q.size() - n0, 1);
    chk("vfy_error", a_error, 1);
    chk("vfy_cpu",   a_cpu,   0);
    chk("vfy_done",  done_cnt - d0, 1);
    corrupt = 1'b0;
`endif

    // Zero-length load: immediate done, error cleared, CPU released.
    n0 = addr_q.size(); d0 = done_cnt;
    pulse_start(0);
    chk("zero_err_clr", a_error, 0);
    repeat (3) @(negedge clk);
    chk("zero_done", done_cnt - d0, 1);
    chk("zero_nwr",  addr_q.size() - n0, 0);
    chk("zero_cpu",  a_cpu, 1);
    chk("zero_busy", a_busy, 0);

    // Main image with 7-cycle stalls; wrap instance crosses 0x3FFC -> 0x0000.
    n0 = addr_q.size(); d0 = done_cnt;
    wait_cycles = 7;
    pulse_start(2);
    for (int i = 0; i < 8; i++) send(img_a[i], 0);
    wait_done(d0);
    chk("main_nwr", addr_q.size() - n0, 2);
    if (addr_q.size() >= n0 + 2) begin
      chk("main_addr0", addr_q[n0],     14'h0000);
      chk("main_data0", data_q[n0],     32'h44332211);
      chk("main_hold0", hold_q[n0],     8);
      chk("main_be0",   be_q[n0],       4'hF);
      chk("main_addr1", addr_q[n0+1],   14'h0004);
      chk("main_data1", data_q[n0+1],   32'h88776655);
      chk("main_hold1", hold_q[n0+1],   8);
      chk("wrap_addr0", waddr_q[n0],    14'h3FFC);
      chk("wrap_addr1", waddr_q[n0+1],  14'h0000);
    end
    chk("main_done",  done_cnt - d0, 1);
    chk("main_error", a_error, 0);
    chk("wrap_error", w_error, 0);
    chk("main_cpu",   a_cpu, 1);
    chk("main_be_idle", a_be, 0);

    // Stream gaps of 5 cycles and a stray start mid-load.
    n0 = addr_q.size(); d0 = done_cnt;
    wait_cycles = 0;
    pulse_start(2);
    fork
      for (int i = 0; i < 8; i++) send(img_b[i], 5);
      begin
        repeat (10) @(negedge clk);
        pulse_start(3);
      end
    join
    wait_done(d0);
    repeat (20) @(negedge clk);
    chk("gap_nwr", addr_q.size() - n0, 2);
    if (addr_q.size() >= n0 + 2) begin
      chk("gap_addr0", addr_q[n0],   14'h0000);
      chk("gap_data0", data_q[n0],   32'hA4A3A2A1);
      chk("gap_addr1", addr_q[n0+1], 14'h0004);
      chk("gap_data1", data_q[n0+1], 32'hA8A7A6A5);
    end
    chk("gap_done",  done_cnt - d0, 1);
    chk("gap_busy",  a_busy, 0);
    chk("gap_error", a_error, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
